// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : morse_pkg
// Purpose  : Shared decoder states, letter codes and Morse timing constants.
// Revision : 1.0 - initial release
// ============================================================================
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [2:0] LETTER_S = 3'd0;
    localparam logic [2:0] LETTER_T = 3'd1;
    localparam logic [2:0] LETTER_U = 3'd2;
    localparam logic [2:0] LETTER_V = 3'd3;
    localparam logic [2:0] LETTER_W = 3'd4;
    localparam logic [2:0] LETTER_X = 3'd5;
    localparam logic [2:0] LETTER_Y = 3'd6;
    localparam logic [2:0] LETTER_Z = 3'd7;

    localparam int DOT_UNITS   = 1;
    localparam int DASH_UNITS  = 3;
    localparam int LETTER_GAP  = 3;
    localparam int MAX_SYMBOLS = 4;

endpackage
`default_nettype wire

// File: rtl/morse_pattern_lut.sv
`default_nettype none
// ============================================================================
// Module   : morse_pattern_lut
// Purpose  : Maps a (symbol count, dot/dash pattern) pair to a letter code.
// Revision : 1.0 - initial release
// ============================================================================
module morse_pattern_lut
    import morse_pkg::*;
(
    input  logic [2:0] i_count,
    input  logic [3:0] i_pattern,
    output logic [2:0] o_letter,
    output logic       o_match
);

    // Pattern holds dashes as 1, oldest symbol in the highest used bit.
    always_comb begin
        o_letter = LETTER_S;
        o_match  = 1'b0;
        case ({i_count, i_pattern})
            {3'd3, 4'b0000}: begin o_letter = LETTER_S; o_match = 1'b1; end
            {3'd1, 4'b0001}: begin o_letter = LETTER_T; o_match = 1'b1; end
            {3'd3, 4'b0001}: begin o_letter = LETTER_U; o_match = 1'b1; end
            {3'd4, 4'b0001}: begin o_letter = LETTER_V; o_match = 1'b1; end
            {3'd3, 4'b0011}: begin o_letter = LETTER_W; o_match = 1'b1; end
            {3'd4, 4'b1001}: begin o_letter = LETTER_X; o_match = 1'b1; end
            {3'd4, 4'b1011}: begin o_letter = LETTER_Y; o_match = 1'b1; end
            {3'd4, 4'b1100}: begin o_letter = LETTER_Z; o_match = 1'b1; end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : morse_decoder
// Purpose  : Tick-sampled serial Morse decoder for the letters S..Z.
// Revision : 1.0 - initial release
// ============================================================================
module morse_decoder
    import morse_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       in,
    output logic [2:0] letter,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    localparam logic [2:0] c_run_dot   = 3'(DOT_UNITS);
    localparam logic [2:0] c_run_dash  = 3'(DASH_UNITS);
    localparam logic [2:0] c_run_limit = 3'(DASH_UNITS + 1);
    localparam logic [2:0] c_gap_end   = 3'(LETTER_GAP);
    localparam logic [2:0] c_max_sym   = 3'(MAX_SYMBOLS);

    state_t     r_state,   w_state_nxt;
    logic [2:0] r_run,     w_run_nxt;
    logic [2:0] r_gap,     w_gap_nxt;
    logic [2:0] r_count,   w_count_nxt;
    logic [3:0] r_pattern, w_pattern_nxt;
    logic [2:0] r_letter,  w_letter_nxt;
    logic       r_valid,   w_valid_nxt;
    logic       r_error,   w_error_nxt;

    logic [2:0] w_run_inc;
    logic [2:0] w_gap_inc;
    logic [2:0] w_lut_letter;
    logic       w_lut_match;

    assign w_run_inc = (r_run == 3'd7) ? r_run : r_run + 3'd1;
    assign w_gap_inc = (r_gap == 3'd7) ? r_gap : r_gap + 3'd1;

    morse_pattern_lut u_lut (
        .i_count   (r_count),
        .i_pattern (r_pattern),
        .o_letter  (w_lut_letter),
        .o_match   (w_lut_match)
    );

    // The gap counter doubles as the consecutive-zero counter while flushing.
    always_comb begin
        w_state_nxt   = r_state;
        w_run_nxt     = r_run;
        w_gap_nxt     = r_gap;
        w_count_nxt   = r_count;
        w_pattern_nxt = r_pattern;
        w_letter_nxt  = r_letter;
        w_valid_nxt   = 1'b0;
        w_error_nxt   = 1'b0;

        if (tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (in) begin
                        w_state_nxt   = ST_MARK;
                        w_run_nxt     = 3'd1;
                        w_gap_nxt     = 3'd0;
                        w_count_nxt   = 3'd0;
                        w_pattern_nxt = 4'd0;
                    end
                end

                ST_MARK: begin
                    if (in) begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == c_run_limit) begin
                            w_error_nxt = 1'b1;
                            w_state_nxt = ST_FLUSH;
                            w_gap_nxt   = 3'd0;
                        end
                    end else if ((r_run != c_run_dot && r_run != c_run_dash) ||
                                 r_count == c_max_sym) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = ST_FLUSH;
                        w_gap_nxt   = 3'd0;
                    end else begin
                        w_pattern_nxt = {r_pattern[2:0], (r_run == c_run_dash)};
                        w_count_nxt   = r_count + 3'd1;
                        w_run_nxt     = 3'd0;
                        w_gap_nxt     = 3'd1;
                        w_state_nxt   = ST_SPACE;
                    end
                end

                ST_SPACE: begin
                    if (!in) begin
                        w_gap_nxt = w_gap_inc;
                        if (w_gap_inc == c_gap_end) begin
                            w_state_nxt = ST_IDLE;
                            if (w_lut_match) begin
                                w_valid_nxt  = 1'b1;
                                w_letter_nxt = w_lut_letter;
                            end else begin
                                w_error_nxt = 1'b1;
                            end
                        end
                    end else if (r_gap == 3'd1) begin
                        w_state_nxt = ST_MARK;
                        w_run_nxt   = 3'd1;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = ST_FLUSH;
                        w_gap_nxt   = 3'd0;
                    end
                end

                ST_FLUSH: begin
                    if (in) begin
                        w_gap_nxt = 3'd0;
                    end else begin
                        w_gap_nxt = w_gap_inc;
                        if (w_gap_inc == c_gap_end) begin
                            w_state_nxt = ST_IDLE;
                            w_gap_nxt   = 3'd0;
                        end
                    end
                end

                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_run     <= 3'd0;
            r_gap     <= 3'd0;
            r_count   <= 3'd0;
            r_pattern <= 4'd0;
            r_letter  <= LETTER_S;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run     <= w_run_nxt;
            r_gap     <= w_gap_nxt;
            r_count   <= w_count_nxt;
            r_pattern <= w_pattern_nxt;
            r_letter  <= w_letter_nxt;
            r_valid   <= w_valid_nxt;
            r_error   <= w_error_nxt;
        end
    end

    assign letter = r_letter;
    assign valid  = r_valid;
    assign error  = r_error;
    assign busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_decoder
// Purpose  : Scoreboard bench for morse_decoder against a symbol-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       in = 1'b0;
    logic [2:0] letter;
    logic       valid;
    logic       error;
    logic       busy;

    morse_decoder dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .in     (in),
        .letter (letter),
        .valid  (valid),
        .error  (error),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         is_err;
        logic [2:0] ltr;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         mon_on = 1'b0;
    bit         exp_busy_nxt = 1'b0;
    bit         exp_busy = 1'b0;
    logic [2:0] exp_letter_nxt = 3'd0;
    logic [2:0] exp_letter = 3'd0;

    string CODES [8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    // Reference model: tone/silence run lengths and the symbol string so far.
    bit    m_active = 1'b0;
    bit    m_flush  = 1'b0;
    int    m_tone   = 0;
    int    m_sil    = 0;
    int    m_zeros  = 0;
    string m_sym    = "";

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        exp_busy   <= exp_busy_nxt;
        exp_letter <= exp_letter_nxt;
    end

    task automatic fail(input string name, input int act, input int req);
        n_bad++;
        if (n_bad <= 40)
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    endtask

    task automatic push_exp(input bit is_err, input logic [2:0] l);
        exp_q.push_back('{due: cyc + 1, is_err: is_err, ltr: l});
    endtask

    task automatic model_error();
        push_exp(1'b1, 3'd0);
        m_flush  = 1'b1;
        m_zeros  = 0;
        m_active = 1'b0;
    endtask

    task automatic model_decode();
        int hit = -1;
        for (int k = 0; k < 8; k++)
            if (CODES[k] == m_sym) hit = k;
        if (hit >= 0) begin
            push_exp(1'b0, 3'(hit));
            exp_letter_nxt = 3'(hit);
        end else begin
            push_exp(1'b1, 3'd0);
        end
    endtask

    task automatic model_tick(input bit b);
        if (m_flush) begin
            if (b) m_zeros = 0;
            else begin
                m_zeros++;
                if (m_zeros == 3) m_flush = 1'b0;
            end
        end else if (!m_active) begin
            if (b) begin
                m_active = 1'b1;
                m_tone   = 1;
                m_sil    = 0;
                m_sym    = "";
            end
        end else if (m_tone > 0) begin
            if (b) begin
                m_tone++;
                if (m_tone >= 4) model_error();
            end else if (m_tone == 2 || m_sym.len() == 4) begin
                model_error();
            end else begin
                if (m_tone == 1) m_sym = {m_sym, "."};
                else             m_sym = {m_sym, "-"};
                m_tone = 0;
                m_sil  = 1;
            end
        end else begin
            if (!b) begin
                m_sil++;
                if (m_sil == 3) begin
                    model_decode();
                    m_active = 1'b0;
                end
            end else if (m_sil == 1) begin
                m_tone = 1;
                m_sil  = 0;
            end else begin
                model_error();
            end
        end
        exp_busy_nxt = m_active || m_flush;
    endtask

    task automatic step(input bit rst, input bit tk, input bit b);
        @(posedge clk);
        #1;
        reset = rst;
        tick  = tk;
        in    = b;
        if (rst) begin
            m_active       = 1'b0;
            m_flush        = 1'b0;
            exp_busy_nxt   = 1'b0;
            exp_letter_nxt = 3'd0;
        end else if (tk) begin
            model_tick(b);
        end
    endtask

    task automatic send(input bit b, input int gap);
        repeat (gap) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1, b);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send(s[i] == "1", gap);
    endtask

    task automatic send_letter(input int k, input int gap, input bit corrupt);
        string c;
        string s;
        int    idx;
        c = CODES[k];
        s = "";
        for (int i = 0; i < c.len(); i++) begin
            if (i > 0) s = {s, "0"};
            if (c[i] == "-") s = {s, "111"};
            else             s = {s, "1"};
        end
        s = {s, "000"};
        if (corrupt) begin
            idx = $urandom_range(0, s.len() - 1);
            s[idx] = (s[idx] == "1") ? "0" : "1";
        end
        send_str(s, gap);
    endtask

    // Monitor: per-cycle busy/letter checks and scoreboard pops on pulses.
    always begin
        @(posedge clk);
        #3;
        if (mon_on) begin
            n_cmp++;
            if (busy !== exp_busy) fail("busy", int'(busy), int'(exp_busy));
            n_cmp++;
            if (letter !== exp_letter) fail("letter_hold", int'(letter), int'(exp_letter));
            n_cmp++;
            if (valid === 1'b1 && error === 1'b1) fail("valid_and_error", 1, 0);
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_cmp++;
                fail("missing_pulse", 0, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (valid === 1'b1 || error === 1'b1) begin
                n_cmp++;
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    if (error !== exp_q[0].is_err)
                        fail("pulse_kind_error", int'(error), int'(exp_q[0].is_err));
                    else if (!exp_q[0].is_err && letter !== exp_q[0].ltr)
                        fail("valid_letter", int'(letter), int'(exp_q[0].ltr));
                    void'(exp_q.pop_front());
                end else begin
                    fail("unexpected_pulse", int'({valid, error}), 0);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                n_cmp++;
                fail("pulse_absent", 0, int'(exp_q[0].ltr));
                void'(exp_q.pop_front());
            end else if (valid !== 1'b0 || error !== 1'b0) begin
                n_cmp++;
                fail("pulse_unknown", int'({valid, error}), 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        mon_on = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        send_str("10101000", 0);                 // S
        send_str("1110101110111000", 0);         // Y
        send_str("111000", 0);                   // T
        send_str("110000", 0);                   // two-unit mark then flush
        send_str("101010101000", 0);             // five dots
        send_str("0", 0);
        send_str("10101000", 0);                 // S after flush
        send_str("11111000", 0);                 // overlong mark, flush restarted
        send_str("10010", 0);                    // two-unit gap
        send_str("000", 0);
        send_str("1110111010", 0);               // partial Z, then reset
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        send_str("10101000", 0);
        send_str("10101000", 7);                 // S, stretched ticks
        send_str("1110101110111000", 7);         // Y, stretched ticks
        send_letter(7, 0, 1'b0);                 // Z
        send_letter(3, 2, 1'b0);                 // V
        send_letter(5, 1, 1'b0);                 // X

        for (int n = 0; n < 200; n++) begin
            int kind;
            int gap;
            kind = $urandom_range(0, 9);
            gap  = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 2);
            if (kind < 6) begin
                send_letter($urandom_range(0, 7), gap, 1'b0);
            end else if (kind < 8) begin
                send_letter($urandom_range(0, 7), gap, 1'b1);
            end else if (kind < 9) begin
                repeat ($urandom_range(1, 12)) send(1'($urandom_range(0, 1)), gap);
            end else begin
                send(1'b1, gap);
                step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            end
            if ($urandom_range(0, 3) == 0) send(1'b0, 0);
        end

        repeat (10) step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (exp_q.size() != 0) fail("leftover_expected", 0, exp_q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on posedge clk.
REQ-002 SHALL have: reset  in  1  synchronous, active-high; overrides all other inputs.
REQ-003 SHALL have: tick  in  1  one-clk strobe per Morse time unit (same strobe that advances the encoder shifter).
REQ-004 SHALL have: in  in  1  serial Morse line (1 = tone); sampled only in cycles with tick=1.
REQ-005 SHALL have: letter  out  3  decoded letter code, S=000 T=001 U=010 V=011 W=100 X=101 Y=110 Z=111.
REQ-006 SHALL have: valid  out  1  one-clk pulse, letter updated in the same cycle.
REQ-007 SHALL have: error  out  1  one-clk pulse on a malformed stream.
REQ-008 SHALL have: busy  out  1  high whenever state is not IDLE.

Function
REQ-009 SHALL implement states IDLE, MARK, SPACE and FLUSH; each transition occurs only on a tick cycle.
REQ-010 IDLE: in=1 -> MARK, run=1, symbol count=0, pattern=0; in=0 -> stay.
REQ-011 MARK: in=1 -> run+1; run reaching 4 -> error pulse, then FLUSH.
REQ-012 MARK, in=0: run=1 appends dot (0), run=3 appends dash (1), run=2 -> error pulse and FLUSH; on a good symbol -> SPACE, gap=1.
REQ-013 Pattern SHALL be a 4-bit register shifted left with the new symbol in the LSB; symbol count is 3 bits.
REQ-014 A fifth symbol SHALL cause an error pulse and FLUSH instead of an append.
REQ-015 SPACE, in=0: gap+1; gap reaching 3 ends the letter.
REQ-016 SPACE, in=1: gap=1 -> MARK, run=1; gap=2 -> error pulse and FLUSH.
REQ-017 End of letter SHALL match (count, pattern): S(3,000) T(1,1) U(3,001) V(4,0001) W(3,011) X(4,1001) Y(4,1011) Z(4,1100).
REQ-018 On a match: valid=1 and letter=code; on no match: error=1 and letter unchanged. Either way -> IDLE.
REQ-019 Latency: valid/error SHALL be registered and asserted in the clk cycle after the tick cycle that sampled the completing bit.
REQ-020 FLUSH SHALL count consecutive in=0 ticks, reset that count on in=1, and go to IDLE after 3.
REQ-021 letter SHALL hold its last value until the next valid; valid and error SHALL never assert together.
REQ-022 Run and gap counters SHALL be 3 bits and saturate; they never wrap.
REQ-023 Non-tick cycles SHALL leave all state unchanged; valid and error are low.

Reset
REQ-024 Reset SHALL set state=IDLE, run=gap=count=pattern=0, letter=000, valid=0, error=0, busy=0 on the next posedge.
REQ-025 Reset mid-letter SHALL discard the partial pattern with no valid or error pulse.
REQ-026 Reset coincident with tick SHALL win; that sample is ignored.

Structure
REQ-027 Shared package morse_pkg SHALL hold the state enum, letter codes and these constants: DOT_UNITS=1, DASH_UNITS=3, LETTER_GAP=3, MAX_SYMBOLS=4.
REQ-028 SHALL contain one combinational sub-module, morse_pattern_lut: (count, pattern) -> (letter, match).
REQ-029 The FSM and counters SHALL live in morse_decoder.

Verification
REQ-030 Stream 1,0,1,0,1,0,0,0 on ticks (S) -> valid=1, letter=000, exactly one cycle after the 3rd zero tick.
REQ-031 Stream 1,1,1,0,1,0,1,1,1,0,1,1,1,0,0,0 (Y) -> valid, letter=110; then stream T -> letter=001.
REQ-032 Stream 1,1,0,0,0 (2-unit mark) -> error pulse, no valid, busy through FLUSH, then IDLE.
REQ-033 Stream 1,0,1,0,1,0,1,0,1,0,0,0 (5 dots) -> error at 5th symbol; FLUSH ends after 3 zeros; next letter decodes.
REQ-034 Reset asserted mid-Z, then stream S -> no pulse during reset, then letter=000.
REQ-035 Stream with tick gaps of 7 idle clk cycles between ticks -> same results as back-to-back ticks.
